// File: rtl/ifu_fetch_if.sv
// Instruction-memory read port between the fetch unit and imem.
// Ports: imem_req/imem_addr (fetch -> mem), imem_rvalid/imem_rdata (mem -> fetch).
// Master = fetch unit, slave = instruction memory.
interface ifu_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr,
                    input  imem_rvalid, input imem_rdata);
    modport slave  (input  imem_req, input imem_addr,
                    output imem_rvalid, output imem_rdata);
endinterface

// File: rtl/ifu_fetch.sv
// F-stage fetch: owns the PC, issues imem word reads, drives F_instr/F_PC/F_PC_plus8.
// Latency: rdata is bypassed to F_instr in its rvalid cycle; 1 instr/cycle with 1-cycle imem.
// Backpressure: FD_en=0 holds pc; a response arriving under stall is parked in r_buf (READY).
// Ports: clk, reset (sync, active-high), FD_en, D_redirect/D_redirect_pc, imem (ifu_fetch_if.master),
//        F_instr, F_PC, F_PC_plus8, F_exc_adel.
// Optional macro IFU_ALIGN_CHECK_EN: misaligned next-PC raises F_exc_adel instead of issuing a read.
module ifu_fetch #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                FD_en,
    input  logic                D_redirect,
    input  logic [31:0]         D_redirect_pc,
    ifu_fetch_if.master         imem,
    output logic [31:0]         F_instr,
    output logic [31:0]         F_PC,
    output logic [31:0]         F_PC_plus8,
    output logic                F_exc_adel
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_READY} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_buf;
    logic        r_redir_pend;
    logic [31:0] r_redir_pc;

    logic        w_real;   // F currently holds a real (non-bubble) instruction
    logic        w_adv;
    logic        w_misal;
    logic [31:0] w_npc;

    always_comb begin
        w_real = ((r_state == S_WAIT) && imem.imem_rvalid) || (r_state == S_READY);
        w_adv  = FD_en && w_real;
        // A same-cycle redirect beats a parked one; the parked one is the delay-slot case.
        if (D_redirect)
            w_npc = D_redirect_pc;
        else if (r_redir_pend)
            w_npc = r_redir_pc;
        else
            w_npc = r_pc + PC_STEP;
`ifdef IFU_ALIGN_CHECK_EN
        w_misal = (w_npc[1:0] != 2'b00);
`else
        w_misal = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_REQ;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        imem.imem_req  = 1'b0;
        imem.imem_addr = w_npc;
        F_instr        = 32'h0;
        case (r_state)
            S_REQ: begin
                // Stale rvalid from before reset is ignored here.
                imem.imem_req  = 1'b1;
                imem.imem_addr = r_pc;
                w_state_nxt    = S_WAIT;
            end
            S_WAIT: begin
                if (imem.imem_rvalid) begin
                    F_instr = imem.imem_rdata;
                    if (FD_en) begin
                        imem.imem_req = !w_misal;
                        w_state_nxt   = w_misal ? S_READY : S_WAIT;
                    end else begin
                        w_state_nxt   = S_READY;
                    end
                end
            end
            S_READY: begin
                F_instr = r_buf;
                if (FD_en) begin
                    imem.imem_req = !w_misal;
                    w_state_nxt   = w_misal ? S_READY : S_WAIT;
                end
            end
            default: w_state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc         <= PC_RESET;
            r_buf        <= 32'h0;
            r_redir_pend <= 1'b0;
            r_redir_pc   <= 32'h0;
        end else if (w_adv) begin
            r_pc         <= w_npc;
            r_redir_pend <= 1'b0;
            if (w_misal)
                r_buf <= 32'h0;
        end else begin
            // Redirect while the delay slot is still in flight: park the target.
            if (D_redirect) begin
                r_redir_pend <= 1'b1;
                r_redir_pc   <= D_redirect_pc;
            end
            if ((r_state == S_WAIT) && imem.imem_rvalid && !FD_en)
                r_buf <= imem.imem_rdata;
        end
    end

`ifdef IFU_ALIGN_CHECK_EN
    logic r_exc;
    always_ff @(posedge clk) begin
        if (reset)
            r_exc <= 1'b0;
        else if (w_adv)
            r_exc <= w_misal;
    end
    assign F_exc_adel = r_exc && (r_state == S_READY);
`else
    assign F_exc_adel = 1'b0;
`endif

    assign F_PC       = r_pc;
    assign F_PC_plus8 = r_pc + 32'd8;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a variable-latency single-outstanding imem model.
// Latency: each vector is one clock; outputs sampled on the falling edge.
// Backpressure: FD_en stalls are part of the vectors.
module tb_ifu_fetch;

    logic        clk;
    logic        reset;
    logic        FD_en;
    logic        D_redirect;
    logic [31:0] D_redirect_pc;
    logic [31:0] F_instr;
    logic [31:0] F_PC;
    logic [31:0] F_PC_plus8;
    logic        F_exc_adel;

    ifu_fetch_if imem_bus ();

    ifu_fetch dut (
        .clk           (clk),
        .reset         (reset),
        .FD_en         (FD_en),
        .D_redirect    (D_redirect),
        .D_redirect_pc (D_redirect_pc),
        .imem          (imem_bus),
        .F_instr       (F_instr),
        .F_PC          (F_PC),
        .F_PC_plus8    (F_PC_plus8),
        .F_exc_adel    (F_exc_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fd;
        logic        rd;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_exc;
    } vec_t;

    int errors = 0;
    int checks = 0;

    // imem model state
    int          mem_lat  = 1;
    logic        mem_busy = 1'b0;
    int          mem_cnt  = 0;
    logic [31:0] mem_addr = 32'h0;

    function automatic logic [31:0] W(input logic [31:0] a);
        return 32'hE000_0000 ^ a;
    endfunction

    function automatic vec_t V(input logic fd, input logic rd, input logic [31:0] rpc,
                               input logic req, input logic [31:0] addr,
                               input logic [31:0] instr, input logic [31:0] pc,
                               input logic exc);
        vec_t v;
        v.fd = fd; v.rd = rd; v.rpc = rpc; v.e_req = req; v.e_addr = addr;
        v.e_instr = instr; v.e_pc = pc; v.e_exc = exc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock: drive at posedge+1, check at the falling edge, then update the memory model.
    task automatic cyc(input vec_t v, input logic rst, input string nm);
        reset         = rst;
        FD_en         = v.fd;
        D_redirect    = v.rd;
        D_redirect_pc = v.rpc;
        if (mem_busy && mem_cnt == 1) begin
            imem_bus.imem_rvalid = 1'b1;
            imem_bus.imem_rdata  = W(mem_addr);
        end else begin
            imem_bus.imem_rvalid = 1'b0;
            imem_bus.imem_rdata  = 32'hDEAD_BEEF;
            if (mem_busy) mem_cnt--;
        end
        #4;
        if (!rst) begin
            chk({nm, "_req"},   {31'h0, imem_bus.imem_req}, {31'h0, v.e_req});
            if (v.e_req)
                chk({nm, "_addr"}, imem_bus.imem_addr, v.e_addr);
            chk({nm, "_instr"}, F_instr, v.e_instr);
            chk({nm, "_pc"},    F_PC, v.e_pc);
            chk({nm, "_pc8"},   F_PC_plus8, v.e_pc + 32'd8);
            chk({nm, "_exc"},   {31'h0, F_exc_adel}, {31'h0, v.e_exc});
        end
        if (imem_bus.imem_rvalid) mem_busy = 1'b0;
        if (imem_bus.imem_req && !rst) begin
            chk({nm, "_one_outstanding"}, {31'h0, mem_busy}, 32'h0);
            mem_busy = 1'b1;
            mem_cnt  = mem_lat;
            mem_addr = imem_bus.imem_addr;
        end
        @(posedge clk);
        #1;
    endtask

    vec_t tbl [12];

    initial begin
        reset = 1'b1; FD_en = 1'b0; D_redirect = 1'b0; D_redirect_pc = 32'h0;
        imem_bus.imem_rvalid = 1'b0; imem_bus.imem_rdata = 32'h0;

        // 1-cycle memory: streaming, redirect during advance, 4-cycle stall.
        tbl[0]  = V(1, 0, 0,        1, 32'h3000, 32'h0,     32'h3000, 0);
        tbl[1]  = V(1, 0, 0,        1, 32'h3004, W(32'h3000), 32'h3000, 0);
        tbl[2]  = V(1, 0, 0,        1, 32'h3008, W(32'h3004), 32'h3004, 0);
        tbl[3]  = V(1, 0, 0,        1, 32'h300C, W(32'h3008), 32'h3008, 0);
        tbl[4]  = V(1, 1, 32'h3100, 1, 32'h3100, W(32'h300C), 32'h300C, 0);
        tbl[5]  = V(1, 0, 0,        1, 32'h3104, W(32'h3100), 32'h3100, 0);
        tbl[6]  = V(0, 0, 0,        0, 32'h0,    W(32'h3104), 32'h3104, 0);
        tbl[7]  = V(0, 0, 0,        0, 32'h0,    W(32'h3104), 32'h3104, 0);
        tbl[8]  = V(0, 0, 0,        0, 32'h0,    W(32'h3104), 32'h3104, 0);
        tbl[9]  = V(0, 0, 0,        0, 32'h0,    W(32'h3104), 32'h3104, 0);
        tbl[10] = V(1, 0, 0,        1, 32'h3108, W(32'h3104), 32'h3104, 0);
        tbl[11] = V(1, 0, 0,        1, 32'h310C, W(32'h3108), 32'h3108, 0);

        @(posedge clk); #1;
        cyc(V(0, 0, 0, 0, 0, 0, 0, 0), 1'b1, "rst");
        for (int i = 0; i < 12; i++)
            cyc(tbl[i], 1'b0, $sformatf("tbl%0d", i));

        // 3-cycle memory: two bubbles, no overlapping request.
        mem_lat = 3;
        cyc(V(1, 0, 0, 1, 32'h3110, W(32'h310C), 32'h310C, 0), 1'b0, "lat3_a");
        cyc(V(1, 0, 0, 0, 0, 32'h0, 32'h3110, 0), 1'b0, "lat3_bub1");
        cyc(V(1, 0, 0, 0, 0, 32'h0, 32'h3110, 0), 1'b0, "lat3_bub2");
        cyc(V(1, 0, 0, 1, 32'h3114, W(32'h3110), 32'h3110, 0), 1'b0, "lat3_b");

        // Redirect while delay slot is in flight; second redirect overwrites the first.
        cyc(V(1, 1, 32'h3200, 0, 0, 32'h0, 32'h3114, 0), 1'b0, "pend1");
        cyc(V(1, 1, 32'h3300, 0, 0, 32'h0, 32'h3114, 0), 1'b0, "pend2");
        cyc(V(1, 0, 0, 1, 32'h3300, W(32'h3114), 32'h3114, 0), 1'b0, "pend_apply");

        // Delay slot parked in READY, redirect issues target directly.
        mem_lat = 1;
        cyc(V(0, 0, 0, 0, 0, 32'h0, 32'h3300, 0), 1'b0, "rdy_bub1");
        cyc(V(0, 0, 0, 0, 0, 32'h0, 32'h3300, 0), 1'b0, "rdy_bub2");
        cyc(V(0, 0, 0, 0, 0, W(32'h3300), 32'h3300, 0), 1'b0, "rdy_park");
        cyc(V(1, 1, 32'h3400, 1, 32'h3400, W(32'h3300), 32'h3300, 0), 1'b0, "rdy_redir");

        // Reset in WAIT with a pending redirect and a stale response in flight.
        mem_lat = 3;
        cyc(V(1, 0, 0, 1, 32'h3404, W(32'h3400), 32'h3400, 0), 1'b0, "pre_rst");
        cyc(V(1, 1, 32'h3500, 0, 0, 32'h0, 32'h3404, 0), 1'b0, "pre_rst_pend");
        cyc(V(1, 0, 0, 0, 0, 0, 0, 0), 1'b1, "mid_rst");
        mem_lat = 1;
        cyc(V(1, 0, 0, 1, 32'h3000, 32'h0, 32'h3000, 0), 1'b0, "post_rst_stale");
        cyc(V(1, 0, 0, 1, 32'h3004, W(32'h3000), 32'h3000, 0), 1'b0, "post_rst_nopend");

        // Misaligned redirect target.
`ifdef IFU_ALIGN_CHECK_EN
        cyc(V(1, 1, 32'h3102, 0, 0, W(32'h3004), 32'h3004, 0), 1'b0, "mis_redir");
        cyc(V(0, 0, 0, 0, 0, 32'h0, 32'h3102, 1), 1'b0, "mis_exc");
        cyc(V(1, 1, 32'h3200, 1, 32'h3200, 32'h0, 32'h3102, 1), 1'b0, "mis_recover");
`else
        cyc(V(1, 1, 32'h3102, 1, 32'h3102, W(32'h3004), 32'h3004, 0), 1'b0, "mis_redir");
        cyc(V(0, 0, 0, 0, 0, W(32'h3102), 32'h3102, 0), 1'b0, "mis_exc");
        cyc(V(1, 1, 32'h3200, 1, 32'h3200, W(32'h3102), 32'h3102, 0), 1'b0, "mis_recover");
`endif
        cyc(V(0, 0, 0, 0, 0, W(32'h3200), 32'h3200, 0), 1'b0, "mis_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
